// File: rtl/spike_aer_tx.sv
// spike_aer_tx: address-event transmitter for the LIF neuron array.
// Each strobed spike frame is captured in a snapshot register. A scanner then
// emits one event per set bit, lowest neuron index first, into a small FIFO.
// The FIFO drains over a valid/ready handshake.
// Optional feature macro AER_TS_EN: when defined, every event also carries
// the frame timestamp. When undefined, event_ts is tied to zero and the
// timestamp state is not built.
module spike_aer_tx #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_NEURONS-1:0]            spike_in,
  input  logic                            spike_valid,
  output logic                            event_valid,
  input  logic                            event_ready,
  output logic [ADDR_W-1:0]               event_addr,
  output logic [TS_W-1:0]                 event_ts,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef AER_TS_EN
  localparam int ENT_W = ADDR_W + TS_W;
`else
  localparam int ENT_W = ADDR_W;
`endif

  logic [N_NEURONS-1:0] pend_q, pend_d;
  logic                 overflow_q, overflow_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     wr_data, head;

  logic [ADDR_W-1:0]    low_idx;
  logic [N_NEURONS-1:0] pend_low_clr;
  logic                 full, push, pop, accept, drop;

`ifdef AER_TS_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d, pend_ts_q, pend_ts_d;
`endif

  // Lowest set index of the snapshot; the downward loop leaves the smallest hit.
  always_comb begin
    low_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = ADDR_W'(i);
    end
  end

  // Scanner / FIFO handshake decode and the frame accept-or-drop decision.
  always_comb begin
    pend_low_clr = pend_q & (pend_q - N_NEURONS'(1));
    full         = (level_q == LVL_W'(FIFO_DEPTH));
    push         = (pend_q != '0) && !full;
    pop          = event_valid && event_ready;
    // A one-hot snapshot whose bit leaves this cycle frees the register in time.
    accept       = (pend_q == '0) || ((pend_low_clr == '0) && push);
    drop         = spike_valid && !accept && (spike_in != '0);
`ifdef AER_TS_EN
    wr_data      = {low_idx, pend_ts_q};
`else
    wr_data      = low_idx;
`endif
  end

  // Next-state for snapshot, sticky overflow, FIFO pointers and occupancy.
  always_comb begin
    pend_d     = pend_q;
    overflow_d = overflow_q | drop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push) pend_d = pend_low_clr;
    if (spike_valid && accept) pend_d = spike_in;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

`ifdef AER_TS_EN
  // Frame counter advances on every strobe; the pre-increment value tags the frame.
  always_comb begin
    ts_cnt_d  = spike_valid ? ts_cnt_q + TS_W'(1) : ts_cnt_q;
    pend_ts_d = (spike_valid && accept) ? ts_cnt_q : pend_ts_q;
  end

  // Timestamp state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q  <= '0;
      pend_ts_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      pend_ts_q <= pend_ts_d;
    end
  end
`endif

  // Control state registers; reset discards snapshot and buffered events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Event storage; contents need no reset because outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Head entry drives the outputs directly; zeroed while the FIFO is empty.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    event_valid = (level_q != '0);
    fifo_level  = level_q;
    overflow    = overflow_q;
    busy        = (pend_q != '0);
`ifdef AER_TS_EN
    event_addr  = event_valid ? head[ENT_W-1:TS_W] : '0;
    event_ts    = event_valid ? head[TS_W-1:0] : '0;
`else
    event_addr  = event_valid ? head : '0;
    event_ts    = '0;
`endif
  end

endmodule

// File: tb/tb_spike_aer_tx.sv
// Self-checking bench for spike_aer_tx: a vector table for the single-frame,
// back-to-back and empty-frame cases, plus hand sequences for backpressure,
// overflow, timestamp wrap and mid-operation reset.
module tb_spike_aer_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spike_in;
  logic       spike_valid;
  logic       event_valid;
  logic       event_ready;
  logic [2:0] event_addr;
  logic [7:0] event_ts;
  logic       overflow;
  logic [3:0] fifo_level;
  logic       busy;

  int checks = 0;
  int errors = 0;

  spike_aer_tx #(.N_NEURONS(8), .ADDR_W(3), .FIFO_DEPTH(8), .TS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
    .event_valid(event_valid), .event_ready(event_ready), .event_addr(event_addr),
    .event_ts(event_ts), .overflow(overflow), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sv;
    logic [7:0] spk;
    logic       rdy;
    logic       v;
    logic [2:0] a;
    logic [7:0] ts;
    logic [3:0] lvl;
    logic       bsy;
    logic       ov;
  } vec_t;

  vec_t tbl [15];

  // Timestamp expected on event_ts: zero when the timestamp feature is absent.
  function automatic logic [7:0] ets(input logic [7:0] t);
`ifdef AER_TS_EN
    return t;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [7:0] spk, input logic rdy);
    spike_valid = sv;
    spike_in    = spk;
    event_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  int bad;

  initial begin
    //          sv  spk    rdy   v    a     ts     lvl   busy  ov
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'd0, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 8'd0, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'd0, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'd0, 4'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h40, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h03, 1'b1, 1'b1, 3'd6, 8'd1, 4'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'd2, 4'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'd2, 4'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'hC0, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd6, 8'd3, 4'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'd3, 4'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0, 4'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", event_valid, 0);
    chk("rst_addr",  event_addr, 0);
    chk("rst_ts",    event_ts, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_busy",  busy, 0);

    // Single frame, back-to-back accept boundary, empty frame while busy.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].sv, tbl[i].spk, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_valid", i), event_valid, tbl[i].v);
      chk($sformatf("tbl%0d_addr", i),  event_addr, tbl[i].a);
      chk($sformatf("tbl%0d_ts", i),    event_ts, ets(tbl[i].ts));
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_busy", i),  busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_ovf", i),   overflow, tbl[i].ov);
    end

    // Backpressure: full frame fills the FIFO exactly, head holds under stall.
    do_reset();
    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_level", fifo_level, 8);
    chk("bp_busy",  busy, 0);
    chk("bp_ovf",   overflow, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!event_valid || event_addr !== 3'd0 || event_ts !== ets(8'd0)) bad++;
      step();
    end
    chk("bp_stable", bad, 0);
    event_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_drain%0d_valid", i), event_valid, 1);
      chk($sformatf("bp_drain%0d_addr", i),  event_addr, i);
      step();
    end
    chk("bp_empty", event_valid, 0);

    // Overflow: second frame arrives while the snapshot still holds many bits.
    do_reset();
    drive(1'b1, 8'hFF, 1'b0);
    step();
    chk("ov_before", overflow, 0);
    drive(1'b1, 8'h0F, 1'b0);
    step();
    chk("ov_set", overflow, 1);
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("ov_level", fifo_level, 8);
    event_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ov_drain%0d_addr", i), event_addr, i);
      step();
    end
    chk("ov_empty",  event_valid, 0);
    chk("ov_sticky", overflow, 1);
    chk("ov_busy",   busy, 0);

    // Empty frames and timestamp wrap.
    do_reset();
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 8'h00, 1'b1);
      step();
      if (event_valid || overflow || busy) bad++;
    end
    chk("empty_frames", bad, 0);
    drive(1'b1, 8'h80, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("wrap_a_valid", event_valid, 1);
    chk("wrap_a_addr",  event_addr, 7);
    chk("wrap_a_ts",    event_ts, ets(8'd255));
    drive(1'b1, 8'h01, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("wrap_b_valid", event_valid, 1);
    chk("wrap_b_addr",  event_addr, 0);
    chk("wrap_b_ts",    event_ts, ets(8'd0));
    step();
    chk("wrap_empty", event_valid, 0);
    chk("wrap_ovf",   overflow, 0);

    // Reset with three events buffered and overflow set.
    do_reset();
    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b1, 8'h0F, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("mr_level_pre", fifo_level, 3);
    chk("mr_ovf_pre",   overflow, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_valid", event_valid, 0);
    chk("mr_level", fifo_level, 0);
    chk("mr_ovf",   overflow, 0);
    chk("mr_busy",  busy, 0);
    event_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (event_valid || fifo_level != 0) bad++;
    end
    chk("mr_no_stale", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
